// File: rtl/tpu_pkg.sv
// Shared types and default widths for the tile loop sequencer.
package tpu_pkg;

  localparam int TILE_IDX_WIDTH  = 16;
  localparam int TILE_ADDR_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tile_loop_state_t;

  // Loop bounds and address plan captured at start. The package widths
  // are the upper bound for the IDX_WIDTH/ADDR_WIDTH parameters of the top.
  typedef struct packed {
    logic [TILE_IDX_WIDTH-1:0]  row_end;
    logic [TILE_IDX_WIDTH-1:0]  col_end;
    logic [TILE_ADDR_WIDTH-1:0] base_addr;
    logic [TILE_ADDR_WIDTH-1:0] row_stride;
  } tile_loop_cfg_t;

endpackage

// File: rtl/tile_loop_ctrl_loop_level.sv
// One level of the nested loop: an index counter with an inclusive end
// compare. Stepping at the end value wraps the index back to 0, which is
// exactly what the inner level needs when the outer level advances.
module loop_level #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] end_val,
  output logic [W-1:0] idx,
  output logic         at_end
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  assign at_end = (idx_q == end_val);
  assign idx    = idx_q;

  // Next index: clear wins, otherwise count up and wrap after the end value.
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = at_end ? '0 : idx_q + W'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/tile_loop_ctrl.sv
// Two-level (rows x cols) loop sequencer emitting one (row, col, addr) beat
// per valid/ready handshake, then a one-cycle done pulse.
// Optional build macro: TILE_LOOP_PERF_EN adds the stall_cycles counter/port.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// row_idx/col_idx/addr/first/last are held unchanged. abort in the same
// cycle cancels that transfer.
module tile_loop_ctrl
  import tpu_pkg::*;
#(
  parameter int IDX_WIDTH  = TILE_IDX_WIDTH,
  parameter int ADDR_WIDTH = TILE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_WIDTH-1:0]  row_end,
  input  logic [IDX_WIDTH-1:0]  col_end,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  row_idx,
  output logic [IDX_WIDTH-1:0]  col_idx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first,
  output logic                  last,
`ifdef TILE_LOOP_PERF_EN
  output logic [31:0]           stall_cycles,
`endif
  output tile_loop_state_t      dbg_state
);

  tile_loop_state_t state_q, state_d;
  tile_loop_cfg_t   cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  // Offset of the current row from base_addr (row_idx * row_stride, wrapped).
  logic [ADDR_WIDTH-1:0] row_off_q, row_off_d;

  logic in_run;
  logic start_acc;
  logic abort_run;
  logic step;
  logic col_at_end;
  logic row_at_end;
  logic finish;
  logic row_wrap;
  logic idx_clear;
  logic [IDX_WIDTH-1:0]  cfg_row_end;
  logic [IDX_WIDTH-1:0]  cfg_col_end;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [ADDR_WIDTH-1:0] cfg_stride;

  assign cfg_row_end = IDX_WIDTH'(cfg_q.row_end);
  assign cfg_col_end = IDX_WIDTH'(cfg_q.col_end);
  assign cfg_base    = ADDR_WIDTH'(cfg_q.base_addr);
  assign cfg_stride  = ADDR_WIDTH'(cfg_q.row_stride);

  assign in_run    = (state_q == RUN);
  assign start_acc = (state_q == IDLE) & start;
  assign abort_run = in_run & abort;
  // An accepted beat: abort takes priority over the handshake.
  assign step      = in_run & out_ready & ~abort;
  assign finish    = step & col_at_end & row_at_end;
  assign row_wrap  = step & col_at_end & ~row_at_end;
  assign idx_clear = start_acc | abort_run;

  loop_level #(.W(IDX_WIDTH)) u_col (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .step    (step),
    .end_val (cfg_col_end),
    .idx     (col_idx),
    .at_end  (col_at_end)
  );

  loop_level #(.W(IDX_WIDTH)) u_row (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .step    (step & col_at_end),
    .end_val (cfg_row_end),
    .idx     (row_idx),
    .at_end  (row_at_end)
  );

  // FSM next state: IDLE -> RUN on start, RUN -> DONE on last beat, abort back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)       state_d = IDLE;
        else if (finish) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config capture and address generation; addresses wrap modulo 2^ADDR_WIDTH.
  always_comb begin
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    row_off_d = row_off_q;
    if (start_acc) begin
      cfg_d.row_end    = TILE_IDX_WIDTH'(row_end);
      cfg_d.col_end    = TILE_IDX_WIDTH'(col_end);
      cfg_d.base_addr  = TILE_ADDR_WIDTH'(base_addr);
      cfg_d.row_stride = TILE_ADDR_WIDTH'(row_stride);
      addr_d           = base_addr;
      row_off_d        = '0;
    end else if (abort_run | finish) begin
      addr_d    = '0;
      row_off_d = '0;
    end else if (row_wrap) begin
      row_off_d = row_off_q + cfg_stride;
      addr_d    = cfg_base + row_off_q + cfg_stride;
    end else if (step) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  // State, config and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      addr_q    <= '0;
      row_off_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      row_off_q <= row_off_d;
    end
  end

`ifdef TILE_LOOP_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of stalled RUN cycles; cleared only by an accepted start.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (in_run && !out_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign busy      = in_run;
  assign out_valid = in_run;
  assign done      = (state_q == DONE);
  assign addr      = addr_q;
  assign first     = in_run & (row_idx == '0) & (col_idx == '0);
  assign last      = in_run & row_at_end & col_at_end;
  assign dbg_state = state_q;

endmodule
